usb_fs_rx: RTL and testbench
============================

USB_FS_RX -- requirements
Module: usb_fs_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 4: clk cycles per USB bit; legal range 3..8.
REQ-002 Parameter FULLSPEED, default 1: 1 = J is (linep,linem)=(1,0); 0 = low-speed, J is (0,1).
REQ-003 clk  input  1  receive sample clock, nominally 12 MHz x OVERSAMPLE.
REQ-004 nreset  input  1  reset; asynchronous assertion, active low.
REQ-005 linep  input  1  USB D+ line, asynchronous to clk.
REQ-006 linem  input  1  USB D- line, asynchronous to clk.
REQ-007 rx_data  output  8  received byte, valid only while rx_valid=1.
REQ-008 rx_valid  output  1  one-cycle pulse per received byte.
REQ-009 rx_active  output  1  high from SYNC completion to end of packet.
REQ-010 rx_eop  output  1  one-cycle pulse on clean EOP (SE0 then J).
REQ-011 rx_error  output  1  one-cycle pulse on SYNC, stuff, SE1 or alignment error.
REQ-012 line_se0  output  1  level: synchronised line currently SE0.

Function
REQ-013 linep/linem SHALL pass a 2-flop synchroniser; all decode uses synchronised values.
REQ-014 Line states: J, K, SE0=(0,0), SE1=(1,1); J/K mapping per FULLSPEED.
REQ-015 Bit timing: phase counter 0..OVERSAMPLE-1, cleared on every J/K transition, free-running otherwise; bit sampled when counter = OVERSAMPLE/2 (integer division).
REQ-016 FSM states: IDLE, SYNC, DATA, EOP, WAITJ.
REQ-017 IDLE: on J->K transition go to SYNC; no outputs asserted.
REQ-018 SYNC: NRZI-decoded bits SHALL be 0,0,0,0,0,0,0,1 (KJKJKJKK); on final 1 go to DATA and set rx_active next cycle.
REQ-019 SYNC mismatch or SE0/SE1 during SYNC: pulse rx_error, go to WAITJ; rx_active stays 0.
REQ-020 NRZI decode: sampled state equal to previous sampled state = 1, different = 0.
REQ-021 Bit unstuff: after six consecutive decoded 1s the next bit is discarded if 0; if 1, pulse rx_error, clear rx_active, go to WAITJ.
REQ-022 Data assembled LSB first; rx_valid pulses and rx_data updates the cycle after the 8th non-stuffed bit is sampled; stuffed bits do not advance the bit count; ones-run counter persists across byte boundaries.
REQ-023 SE0 sampled in DATA: go to EOP; if bit count mod 8 != 0, pulse rx_error, no rx_valid for the partial byte.
REQ-024 EOP: J sampled after SE0 pulses rx_eop (if no alignment error), clears rx_active, returns to IDLE; K or SE1 sampled pulses rx_error, clears rx_active, goes to WAITJ.
REQ-025 SE1 sampled in any state except IDLE/WAITJ: pulse rx_error, clear rx_active, go to WAITJ.
REQ-026 WAITJ: remain until J sampled for one full bit time, then IDLE.
REQ-027 rx_valid, rx_eop and rx_error SHALL never assert in the same cycle except rx_error alone; each is at most one cycle wide.
REQ-028 line_se0 follows the synchronised line with 2-cycle latency, independent of FSM.

Reset
REQ-029 nreset low SHALL immediately force: rx_data=0, rx_valid=0, rx_active=0, rx_eop=0, rx_error=0, line_se0=0, FSM=IDLE, all counters and synchroniser flops to J-equivalent idle state.
REQ-030 Reset release mid-packet: block waits in IDLE for a fresh J->K; no byte of the interrupted packet is reported.

Structure
REQ-031 Shared package usb_fs_pkg holds line-state encoding, FSM state enum, SYNC pattern and stuff-limit (6) constants.
REQ-032 One sub-module usb_rx_dpll: synchroniser, line-state decode, phase counter; outputs sample strobe and sampled line state.

Verification (OVERSAMPLE=4, FULLSPEED=1)
REQ-033 SYNC + byte 0xA5 + SE0 x2 bits + J -> one rx_valid with rx_data=0xA5, then one rx_eop; rx_error never set.
REQ-034 SYNC + 0xFF,0xFF with correct stuffing + EOP -> two rx_valid, both 0xFF; stuffed bits ignored.
REQ-035 SYNC + seven consecutive 1s -> rx_error pulse, rx_active low, no rx_valid, returns to IDLE after J.
REQ-036 SYNC + 5 data bits + SE0 -> rx_error, no rx_valid, no rx_eop.
REQ-037 Bit periods alternating 3 and 5 clocks, byte 0x3C -> rx_data=0x3C, no error.
REQ-038 nreset low during second byte -> all outputs 0 asynchronously; after release, next full packet with 0x5A decodes correctly.

Source files
------------

// File: rtl/usb_fs_pkg.sv
`default_nettype none
// ============================================================================
// usb_fs_pkg : line-state encoding, receiver FSM states and framing constants
// Revision   : 1.0
// ============================================================================
package usb_fs_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_WAITJ = 3'd4
  } rx_state_t;

  // Decoded SYNC bits in arrival order (bit 0 first): seven 0s then a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  function automatic line_t decode_line(input logic p, input logic m, input logic fs);
    line_t ls;
    case ({p, m})
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      2'b10:   ls = fs ? LS_J : LS_K;
      default: ls = fs ? LS_K : LS_J;
    endcase
    return ls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_dpll.sv
`default_nettype none
// ============================================================================
// usb_rx_dpll : line synchroniser, line-state decode and bit-phase recovery
// Revision    : 1.0
// ============================================================================
module usb_rx_dpll
  import usb_fs_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 4,
  parameter bit          FULLSPEED  = 1'b1
) (
  input  logic  clk,
  input  logic  nreset,
  input  logic  linep_i,
  input  logic  linem_i,
  output logic  sample_o,
  output line_t lstate_o,
  output logic  se0_o
);

  localparam int unsigned   CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] PH_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] PH_SAMPLE = CW'(OVERSAMPLE / 2);
  localparam logic          J_P       = FULLSPEED;
  localparam logic          J_M       = !FULLSPEED;

  logic [1:0]    p_q, m_q;
  line_t         cur, prev_q, lstate_q;
  logic [CW-1:0] ph_q, ph_d;
  logic          sample_q;

  assign cur = decode_line(p_q[1], m_q[1], FULLSPEED);

  // Phase restarts at 0 on the cycle a line change is seen, so the strobe
  // lands OVERSAMPLE/2 cycles into every bit that follows a transition.
  always_comb begin
    ph_d = ph_q + CW'(1);
    if (cur != prev_q || ph_q == PH_LAST) ph_d = '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      p_q      <= {2{J_P}};
      m_q      <= {2{J_M}};
      prev_q   <= LS_J;
      lstate_q <= LS_J;
      ph_q     <= '0;
      sample_q <= 1'b0;
    end else begin
      p_q      <= {p_q[0], linep_i};
      m_q      <= {m_q[0], linem_i};
      prev_q   <= cur;
      lstate_q <= cur;
      ph_q     <= ph_d;
      sample_q <= (ph_d == PH_SAMPLE);
    end
  end

  assign sample_o = sample_q;
  assign lstate_o = lstate_q;
  assign se0_o    = (cur == LS_SE0);

endmodule
`default_nettype wire

// File: rtl/usb_fs_rx.sv
`default_nettype none
// ============================================================================
// usb_fs_rx : USB full/low-speed receiver - SYNC detect, NRZI, unstuff, EOP
// Revision  : 1.0
// ============================================================================
module usb_fs_rx
  import usb_fs_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 4,
  parameter bit          FULLSPEED  = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       linep,
  input  logic       linem,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       line_se0
);

  logic      sample;
  line_t     lstate;
  logic      dbit;

  rx_state_t state_q, state_d;
  line_t     prev_q, prev_d;
  logic [2:0] sync_cnt_q, sync_cnt_d, bit_cnt_q, bit_cnt_d, ones_q, ones_d;
  logic [3:0] jcnt_q, jcnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic       valid_q, valid_d, active_q, active_d, eop_q, eop_d;
  logic       error_q, error_d, align_q, align_d;

  usb_rx_dpll #(.OVERSAMPLE(OVERSAMPLE), .FULLSPEED(FULLSPEED)) u_dpll (
    .clk      (clk),
    .nreset   (nreset),
    .linep_i  (linep),
    .linem_i  (linem),
    .sample_o (sample),
    .lstate_o (lstate),
    .se0_o    (line_se0)
  );

  assign dbit = (lstate == prev_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    sync_cnt_d = sync_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    jcnt_d     = jcnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    active_d   = active_q;
    align_d    = align_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    error_d    = 1'b0;
    if (sample) prev_d = lstate;

    case (state_q)
      ST_IDLE: begin
        if (sample && prev_q == LS_J && lstate == LS_K) begin
          state_d    = ST_SYNC;
          sync_cnt_d = 3'd1;
        end
      end
      ST_SYNC: if (sample) begin
        if (lstate == LS_SE0 || lstate == LS_SE1 || dbit != SYNC_PATTERN[sync_cnt_q]) begin
          error_d = 1'b1;
          state_d = ST_WAITJ;
        end else if (sync_cnt_q == 3'd7) begin
          // Stuffing run counts data bits only; the SYNC's closing 1 is excluded.
          state_d   = ST_DATA;
          active_d  = 1'b1;
          bit_cnt_d = 3'd0;
          ones_d    = 3'd0;
        end else begin
          sync_cnt_d = sync_cnt_q + 3'd1;
        end
      end
      ST_DATA: if (sample) begin
        case (lstate)
          LS_SE1: begin
            error_d  = 1'b1;
            active_d = 1'b0;
            state_d  = ST_WAITJ;
          end
          LS_SE0: begin
            state_d = ST_EOP;
            align_d = (bit_cnt_q != 3'd0);
            error_d = (bit_cnt_q != 3'd0);
          end
          default: begin
            if (ones_q == STUFF_LIMIT) begin
              if (dbit) begin
                error_d  = 1'b1;
                active_d = 1'b0;
                state_d  = ST_WAITJ;
              end else begin
                ones_d = 3'd0;
              end
            end else begin
              ones_d    = dbit ? ones_q + 3'd1 : 3'd0;
              shift_d   = {dbit, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                valid_d = 1'b1;
                data_d  = {dbit, shift_q[7:1]};
              end
            end
          end
        endcase
      end
      ST_EOP: if (sample) begin
        case (lstate)
          LS_SE0: ;
          LS_J: begin
            eop_d    = !align_q;
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end
          default: begin
            error_d  = 1'b1;
            active_d = 1'b0;
            state_d  = ST_WAITJ;
          end
        endcase
      end
      ST_WAITJ: begin
        jcnt_d = (lstate == LS_J) ? jcnt_q + 4'd1 : 4'd0;
        if (lstate == LS_J && jcnt_q == 4'(OVERSAMPLE - 1)) begin
          state_d = ST_IDLE;
          jcnt_d  = 4'd0;
          prev_d  = LS_J;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      prev_q     <= LS_J;
      sync_cnt_q <= 3'd0;
      bit_cnt_q  <= 3'd0;
      ones_q     <= 3'd0;
      jcnt_q     <= 4'd0;
      shift_q    <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sync_cnt_q <= sync_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      jcnt_q     <= jcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      error_q    <= error_d;
      align_q    <= align_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_active = active_q;
  assign rx_eop    = eop_q;
  assign rx_error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_rx.sv
`default_nettype none
// ============================================================================
// tb_usb_fs_rx : packet-level encoder/scoreboard bench for usb_fs_rx
// Revision     : 1.0
// ============================================================================
module tb_usb_fs_rx;

  localparam int OS = 4;
  localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00, S1 = 2'b11;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       linep = 1'b1, linem = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_error, line_se0;

  usb_fs_rx #(.OVERSAMPLE(OS), .FULLSPEED(1'b1)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .linep     (linep),
    .linem     (linem),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_eop    (rx_eop),
    .rx_error  (rx_error),
    .line_se0  (line_se0)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed activity for the current scenario.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  n_eop, n_err, viol;
  bit  act_seen, pv, pe, pr;

  // Line stimulus built from bytes: NRZI with bit stuffing.
  logic [1:0] line_q[$];
  logic [1:0] nrzi;
  int  ones;
  int  mode = 0;
  bit  alt = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (rx_valid) got_q.push_back(rx_data);
    n_eop += int'(rx_eop);
    n_err += int'(rx_error);
    if (int'(rx_valid) + int'(rx_eop) + int'(rx_error) > 1) viol++;
    if ((rx_valid && pv) || (rx_eop && pe) || (rx_error && pr)) viol++;
    pv = rx_valid; pe = rx_eop; pr = rx_error;
    if (rx_active) act_seen = 1'b1;
  endtask

  task automatic begin_scn();
    got_q.delete(); exp_q.delete(); line_q.delete();
    n_eop = 0; n_err = 0; viol = 0;
    act_seen = 1'b0; pv = 1'b0; pe = 1'b0; pr = 1'b0;
  endtask

  task automatic idle(input int n);
    {linep, linem} = SJ;
    repeat (n) tick();
  endtask

  task automatic add_sync();
    line_q.push_back(SK); line_q.push_back(SJ); line_q.push_back(SK); line_q.push_back(SJ);
    line_q.push_back(SK); line_q.push_back(SJ); line_q.push_back(SK); line_q.push_back(SK);
    nrzi = SK;
    ones = 0;
  endtask

  task automatic add_raw(input bit b);
    if (!b) nrzi = (nrzi == SJ) ? SK : SJ;
    line_q.push_back(nrzi);
  endtask

  task automatic add_byte(input logic [7:0] v);
    exp_q.push_back(v);
    for (int i = 0; i < 8; i++) begin
      add_raw(v[i]);
      ones = v[i] ? ones + 1 : 0;
      if (ones == 6) begin
        add_raw(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic add_eop();
    line_q.push_back(S0); line_q.push_back(S0); line_q.push_back(SJ);
  endtask

  // Drives line_q; stops before symbol index 'stop' when stop >= 0.
  task automatic send_line(input int stop);
    int per;
    for (int i = 0; i < line_q.size(); i++) begin
      if (stop >= 0 && i == stop) return;
      {linep, linem} = line_q[i];
      per = (mode != 0) ? (alt ? 3 : 5) : OS;
      alt = ~alt;
      repeat (per) tick();
    end
  endtask

  task automatic finish_scn(input string tag, input int exp_eop, input int exp_err, input bit exp_act);
    idle(10 * OS);
    check({tag, "/nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s/byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "/eop"}, 32'(n_eop), 32'(exp_eop));
    check({tag, "/err"}, 32'(n_err), 32'(exp_err));
    check({tag, "/active_seen"}, 32'(act_seen), 32'(exp_act));
    check({tag, "/active_end"}, 32'(rx_active), 32'd0);
    check({tag, "/pulse_rules"}, 32'(viol), 32'd0);
  endtask

  task automatic good_packet(input string tag, input int nbytes, input bit rnd, input logic [7:0] v);
    begin_scn();
    add_sync();
    for (int i = 0; i < nbytes; i++) add_byte(rnd ? 8'($urandom_range(0, 255)) : v);
    add_eop();
    send_line(-1);
    finish_scn(tag, 1, 0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/rx_data"},   32'(rx_data),   32'd0);
    check({tag, "/rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, "/rx_active"}, 32'(rx_active), 32'd0);
    check({tag, "/rx_eop"},    32'(rx_eop),    32'd0);
    check({tag, "/rx_error"},  32'(rx_error),  32'd0);
    check({tag, "/line_se0"},  32'(line_se0),  32'd0);
  endtask

  initial begin
    begin_scn();
    repeat (3) tick();
    check_all_zero("reset");
    nreset = 1'b1;
    idle(10 * OS);

    // line_se0 two-cycle latency, no FSM activity on SE0 while idle.
    begin_scn();
    {linep, linem} = S0;
    tick();
    check("se0_lat1", 32'(line_se0), 32'd0);
    tick();
    check("se0_lat2", 32'(line_se0), 32'd1);
    repeat (6) tick();
    finish_scn("se0_idle", 0, 0, 1'b0);

    good_packet("a5", 1, 1'b0, 8'hA5);
    good_packet("ff_ff", 2, 1'b0, 8'hFF);
    mode = 1;
    good_packet("jitter_3c", 1, 1'b0, 8'h3C);
    for (int k = 0; k < 8; k++) begin
      mode = int'($urandom_range(0, 1));
      good_packet($sformatf("rand%0d", k), int'($urandom_range(1, 4)), 1'b1, 8'h00);
    end
    mode = 0;

    // Seven decoded 1s: stuff violation, then recovery.
    begin_scn();
    add_sync();
    for (int i = 0; i < 7; i++) add_raw(1'b1);
    send_line(-1);
    finish_scn("stuff_err", 0, 1, 1'b1);
    good_packet("after_stuff", 1, 1'b1, 8'h00);

    // Five data bits then EOP: alignment error only.
    begin_scn();
    add_sync();
    for (int i = 0; i < 5; i++) add_raw(1'($urandom_range(0, 1)));
    add_eop();
    send_line(-1);
    finish_scn("align_err", 0, 1, 1'b1);

    // Corrupted SYNC (KJKJKKKK).
    begin_scn();
    line_q.push_back(SK); line_q.push_back(SJ); line_q.push_back(SK); line_q.push_back(SJ);
    line_q.push_back(SK); line_q.push_back(SK); line_q.push_back(SK); line_q.push_back(SK);
    send_line(-1);
    finish_scn("sync_err", 0, 1, 1'b0);
    good_packet("after_sync", 1, 1'b1, 8'h00);

    // SE1 inside data.
    begin_scn();
    add_sync();
    for (int i = 0; i < 3; i++) add_raw(1'($urandom_range(0, 1)));
    line_q.push_back(S1); line_q.push_back(S1);
    send_line(-1);
    finish_scn("se1_err", 0, 1, 1'b1);

    // Reset during the second byte.
    begin_scn();
    add_sync();
    add_byte(8'h11);
    add_byte(8'h22);
    add_eop();
    send_line(20);
    check("mid_pkt/nbytes", 32'(got_q.size()), 32'd1);
    check("mid_pkt/active", 32'(rx_active), 32'd1);
    #2 nreset = 1'b0;
    #1 check_all_zero("async_rst");
    {linep, linem} = SJ;
    repeat (10) tick();
    nreset = 1'b1;
    idle(10 * OS);
    good_packet("post_rst_5a", 1, 1'b0, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
